// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity/stop codes and
// the stop-length helper. Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [2:0] PARITY_NONE  = 3'b000;
    localparam logic [2:0] PARITY_EVEN  = 3'b001;
    localparam logic [2:0] PARITY_ODD   = 3'b010;
    localparam logic [2:0] PARITY_MARK  = 3'b011;
    localparam logic [2:0] PARITY_SPACE = 3'b100;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Number of s_ticks the line stays high for a given stop code;
    // the unused code 11 behaves as two stop bits.
    function automatic int stop_ticks(input logic [1:0] code, input int oversample);
        case (code)
            STOP_1:   return oversample;
            STOP_1P5: return (3 * oversample) / 2;
            default:  return 2 * oversample;
        endcase
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a variable-length data field. Only the
// lowest 'len' bits of 'data' take part in the XOR.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int LEN_W    = $clog2(DBIT_MAX + 1)
) (
    input  logic [DBIT_MAX-1:0] data,
    input  logic [LEN_W-1:0]    len,
    input  logic [2:0]          mode,
    output logic                par_bit
);

    logic x;

    // Masked XOR of the transmitted bits, then mapped by parity mode
    always_comb begin
        x = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (LEN_W'(i) < len) x = x ^ data[i];
        end
        case (mode)
            PARITY_EVEN:  par_bit = x;
            PARITY_ODD:   par_bit = ~x;
            PARITY_MARK:  par_bit = 1'b1;
            PARITY_SPACE: par_bit = 1'b0;
            default:      par_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, 1..DBIT_MAX data bits
// LSB first, optional parity, 1/1.5/2 stop bits. Frame configuration is
// captured at acceptance so the host may change inputs mid-frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    localparam int LEN_W     = $clog2(DBIT_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tx_start,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] din,
    input  logic [LEN_W-1:0]    data_len,
    input  logic [2:0]          parity_mode,
    input  logic [1:0]          stop_bits,
    output logic                tx_ready,
    output logic                tx_done_tick,
    output logic                tx
);

    // Wide enough for the longest stop period (2*OVERSAMPLE-1)
    localparam int S_W = $clog2(2 * OVERSAMPLE);
    localparam logic [S_W-1:0] BIT_LAST = S_W'(OVERSAMPLE - 1);

    uart_state_t state_q, state_d;
    logic [S_W-1:0]      s_q, s_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic [1:0]          stop_q, stop_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    len_eff;
    logic                par_bit_acc;
    logic                par_en_acc;
    logic [S_W-1:0]      stop_last;

    // Out-of-range lengths fall back to the full data width
    assign len_eff = (data_len == '0 || data_len > LEN_W'(DBIT_MAX)) ?
                     LEN_W'(DBIT_MAX) : data_len;

    assign par_en_acc = (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD) ||
                        (parity_mode == PARITY_MARK) || (parity_mode == PARITY_SPACE);

    assign stop_last = S_W'(stop_ticks(stop_q, OVERSAMPLE) - 1);

    uart_parity_gen #(
        .DBIT_MAX (DBIT_MAX),
        .LEN_W    (LEN_W)
    ) u_parity (
        .data    (din),
        .len     (len_eff),
        .mode    (parity_mode),
        .par_bit (par_bit_acc)
    );

    // State, counters, latched configuration and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output decode; bit boundaries advance only on s_tick
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shift_d   = shift_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shift_d   = din;
                    len_d     = len_eff;
                    par_en_d  = par_en_acc;
                    par_bit_d = par_bit_acc;
                    stop_d    = stop_bits;
                    s_d       = '0;
                    n_d       = '0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        if (n_q == len_q - LEN_W'(1)) begin
                            if (par_en_q) begin
                                tx_d    = par_bit_q;
                                state_d = PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = STOP;
                            end
                        end else begin
                            shift_d = shift_q >> 1;
                            n_d     = n_q + 1'b1;
                            tx_d    = shift_d[0];
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == stop_last) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready     = (state_q == IDLE);
    assign tx           = tx_q;
    assign tx_done_tick = done_q;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter and the successor to the fixed 8N1 transmitter.
- Serialises one frame per accepted request: start bit, 1..DBIT_MAX data bits (LSB first), optional parity bit, then 1, 1.5 or 2 stop bits.
- Sits between the TX FIFO / host logic and the pad.
- Shares the baud-rate generator's s_tick (OVERSAMPLE ticks per bit) with the receiver.

Parameters:
DBIT_MAX, 8, widest supported data field; din width.
OVERSAMPLE, 16, s_ticks per bit period; must be even and at least 4.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
tx_start  in  1  request strobe; honoured only while tx_ready=1.
s_tick  in  1  oversample enable from the baud generator, one clk wide.
din  in  DBIT_MAX  frame data; bit 0 is sent first.
data_len  in  clog2(DBIT_MAX+1)  number of data bits, 1..DBIT_MAX.
parity_mode  in  3  000 none, 001 even, 010 odd, 011 mark, 100 space; other codes act as none.
stop_bits  in  2  00 one, 01 one-and-half, 10 two; 11 acts as two.
tx_ready  out  1  high only in IDLE.
tx_done_tick  out  1  one-clk pulse when a frame completes.
tx  out  1  serial line; idle high.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - tx=1, tx_done_tick=0, tx_ready=1.
  - All counters and the shift register are cleared.
  - Reset mid-frame aborts the frame immediately; line goes high with no done pulse.
- All outputs are registered except tx_ready, which is decoded from state.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On the clk edge where tx_start=1, the block latches din, data_len, parity_mode and stop_bits.
  - The tick counter s is cleared and the FSM enters START. tx=0 from that same edge, so latency is 1 clk.
  - An s_tick in the acceptance cycle is ignored.
- Configuration inputs are don't-care after acceptance; changing them mid-frame has no effect.
- data_len=0 or data_len>DBIT_MAX is treated as DBIT_MAX.
- Bit timing:
  - s increments on each s_tick.
  - A bit ends on the s_tick where s==OVERSAMPLE-1. s then returns to 0 and the next bit value appears on tx at that edge.
- START: tx=0 for OVERSAMPLE ticks, then DATA with bit counter n=0.
- DATA:
  - tx = shift[0]. At the end of each bit, shift>>1 and n increments.
  - After bit n==data_len-1, go to PARITY if the latched mode is not none; otherwise go to STOP.
- PARITY:
  - tx = parity bit for OVERSAMPLE ticks, then STOP.
  - even = XOR of the data_len transmitted bits; odd = its inverse; mark=1; space=0.
  - Bits of din above data_len never affect parity.
- STOP:
  - tx=1 for OVERSAMPLE, 3*OVERSAMPLE/2 or 2*OVERSAMPLE ticks, per the latched stop_bits.
  - On the final tick: state=IDLE and tx_done_tick=1 for exactly one clk.
- tx_start asserted outside IDLE is ignored; it is not queued.
- tx_start in the clk after tx_done_tick is accepted. Minimum inter-frame gap is the stop time plus 1 clk.
- If s_tick never arrives, the FSM holds its state and tx holds its value.
- The tick counter width must hold 2*OVERSAMPLE-1 without wrap.

Decomposition:
- Package uart_pkg holds:
  - state encodings;
  - PARITY_NONE/EVEN/ODD/MARK/SPACE codes;
  - STOP_1/STOP_1P5/STOP_2 codes;
  - a function stop_ticks(code, OVERSAMPLE).
- The receiver will share this package.
- One sub-module, uart_parity_gen: combinational. Inputs are data, len and mode; output is the parity bit, computed as a masked XOR. The transmitter calls it on the latched data at acceptance.

Test Plan:
1. OVERSAMPLE=16, s_tick every clk; din=8'h55, data_len=8, parity none, stop 1 -> tx: 0,1,0,1,0,1,0,1,0,1, each bit 16 clk; tx_done_tick once at clk 160 after acceptance; tx_ready low throughout.
2. din=8'h07, len=8, even parity, stop 2 -> parity bit=1; stop high for 32 ticks; total 11 bits + extra stop = 192 ticks. The same frame with odd parity -> parity bit=0.
3. din=8'hFF, data_len=5, mark parity, stop 1.5 -> five 1s, parity 1, stop 24 ticks. data_len=5, even, din=8'hE0 -> parity 0, upper bits ignored.
4. s_tick every 4 clk; tx_start pulsed again mid-DATA -> second request ignored; exactly one tx_done_tick; frame timing uses only ticks.
5. reset_n pulled low mid-DATA, asynchronously between clk edges -> tx=1 and tx_ready=1 immediately; no tx_done_tick. After release, a new frame (din=8'hA3) is transmitted correctly.
6. Back-to-back: tx_start held high continuously -> frames separated by exactly stop time + 1 clk of idle; tx_done_tick once per frame.
